// File: rtl/photonic_rx_array_if.sv
// Bundle between the condition sources / configuration side and the
// multi-channel photonic receiver: condition inputs, mode and holdoff go in,
// per-channel switch controls and status come out.
interface photonic_rx_array_if #(
  parameter int CHANNELS  = 4,
  parameter int HOLDOFF_W = 8,
  parameter int COUNT_W   = 8
);
  logic [CHANNELS-1:0]         cond;
  logic [1:0]                  mode;
  logic [HOLDOFF_W-1:0]        holdoff;
  logic [CHANNELS-1:0]         signal;
  logic [CHANNELS-1:0]         busy;
  logic [CHANNELS-1:0]         overrun;
  logic [CHANNELS*COUNT_W-1:0] acc_count;

  // Source / controller side
  modport master (
    output cond, mode, holdoff,
    input  signal, busy, overrun, acc_count
  );

  // Receiver side
  modport slave (
    input  cond, mode, holdoff,
    output signal, busy, overrun, acc_count
  );
endinterface

// File: rtl/photonic_rx_array.sv
// Multi-channel photonic switch receiver. Each channel synchronises its
// asynchronous condition bit, detects rising edges, and drives a switch
// control in toggle / follow / pulse / hold mode, with a programmable holdoff
// window, a sticky overrun flag and a saturating accepted-event counter.
// SYNC_STAGES must be at least 2.
module photonic_rx_array #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 8,
  parameter int COUNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  photonic_rx_array_if.slave  bus
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_FOLLOW = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [CHANNELS-1:0]         signal_w;
  logic [CHANNELS-1:0]         busy_w;
  logic [CHANNELS-1:0]         overrun_w;
  logic [CHANNELS*COUNT_W-1:0] acc_w;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   cond_d_reg;
      logic                   sig_reg, sig_next;
      logic                   ovr_reg, ovr_next;
      logic [HOLDOFF_W-1:0]   cnt_reg, cnt_next;
      logic [COUNT_W-1:0]     acc_reg, acc_next;
      logic                   cond_s, rise, idle, accept, reject;

      assign cond_s = sync_reg[SYNC_STAGES-1];
      assign rise   = cond_s & ~cond_d_reg;
      assign idle   = (cnt_reg == '0);
      // Accept/reject use the current counter value, so a rise landing on the
      // cycle the counter reaches zero is already accepted.
      assign accept = rise & idle & (bus.mode != MODE_HOLD);
      assign reject = rise & ~idle &
                      ((bus.mode == MODE_TOGGLE) | (bus.mode == MODE_PULSE));

      // Next-state for holdoff counter, event counter, overrun and switch output
      always_comb begin
        cnt_next = cnt_reg;
        acc_next = acc_reg;
        ovr_next = ovr_reg | reject;
        sig_next = sig_reg;
        if (accept) begin
          cnt_next = bus.holdoff;
        end else if (!idle) begin
          cnt_next = cnt_reg - HOLDOFF_W'(1);
        end
        if (accept && (acc_reg != '1)) begin
          acc_next = acc_reg + COUNT_W'(1);
        end
        case (bus.mode)
          MODE_TOGGLE: if (accept) sig_next = ~sig_reg;
          MODE_FOLLOW: sig_next = cond_s;
          MODE_PULSE: begin
            if (accept)    sig_next = 1'b1;
            else if (idle) sig_next = 1'b0;
          end
          default: sig_next = sig_reg;  // hold: output frozen
        endcase
      end

      // Channel state registers; reset is asynchronous, clr is a synchronous clear
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg   <= '0;
          cond_d_reg <= 1'b0;
          cnt_reg    <= '0;
          acc_reg    <= '0;
          ovr_reg    <= 1'b0;
          sig_reg    <= 1'b0;
        end else if (clr) begin
          sync_reg   <= '0;
          cond_d_reg <= 1'b0;
          cnt_reg    <= '0;
          acc_reg    <= '0;
          ovr_reg    <= 1'b0;
          sig_reg    <= 1'b0;
        end else begin
          sync_reg   <= {sync_reg[SYNC_STAGES-2:0], bus.cond[gi]};
          cond_d_reg <= cond_s;
          cnt_reg    <= cnt_next;
          acc_reg    <= acc_next;
          ovr_reg    <= ovr_next;
          sig_reg    <= sig_next;
        end
      end

      assign signal_w[gi]                  = sig_reg;
      assign busy_w[gi]                    = ~idle;
      assign overrun_w[gi]                 = ovr_reg;
      assign acc_w[gi*COUNT_W +: COUNT_W]  = acc_reg;
    end
  endgenerate

  assign bus.signal    = signal_w;
  assign bus.busy      = busy_w;
  assign bus.overrun   = overrun_w;
  assign bus.acc_count = acc_w;

endmodule

// File: tb/tb_photonic_rx_array.sv
// Scoreboard bench for photonic_rx_array: stimulus pushes expected snapshots
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_photonic_rx_array;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  photonic_rx_array_if #(.CHANNELS(4), .HOLDOFF_W(8), .COUNT_W(4)) bus ();

  photonic_rx_array #(
    .CHANNELS(4), .SYNC_STAGES(2), .HOLDOFF_W(8), .COUNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // en bits: [3] signal, [2] busy, [1] overrun, [0] acc_count
  typedef struct {
    int          cyc;
    string       name;
    bit [3:0]    en;
    logic [3:0]  sig;
    logic [3:0]  busy;
    logic [3:0]  ovr;
    logic [15:0] acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic expect_at(input int rel, input string nm, input bit [3:0] en,
                           input logic [3:0] s, input logic [3:0] b,
                           input logic [3:0] o, input logic [15:0] a);
    exp_t e;
    e.cyc = cyc_cnt + rel; e.name = nm; e.en = en;
    e.sig = s; e.busy = b; e.ovr = o; e.acc = a;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld,
                     input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s at cyc %0d: got=%h want=%h", nm, fld, cyc_cnt, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc_cnt) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s missed: due cyc %0d, now %0d", mon_e.name, mon_e.cyc, cyc_cnt);
      end else begin
        if (mon_e.en[3]) chk(mon_e.name, "signal",  {12'h0, bus.signal},  {12'h0, mon_e.sig});
        if (mon_e.en[2]) chk(mon_e.name, "busy",    {12'h0, bus.busy},    {12'h0, mon_e.busy});
        if (mon_e.en[1]) chk(mon_e.name, "overrun", {12'h0, bus.overrun}, {12'h0, mon_e.ovr});
        if (mon_e.en[0]) chk(mon_e.name, "acc",     bus.acc_count,        mon_e.acc);
        $display("cyc %0d %-14s sig=%b busy=%b ovr=%b acc=%h", cyc_cnt, mon_e.name,
                 bus.signal, bus.busy, bus.overrun, bus.acc_count);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cond = 4'hF; bus.mode = 2'b00; bus.holdoff = 8'd0;

    // Reset held with cond high, then release: toggle exactly 2 edges later
    step(3);
    expect_at(0, "reset_hold", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(2, "rel_early",  4'h9, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(3, "rel_toggle", 4'hF, 4'hF, 4'h0, 4'h0, 16'h1111);
    reset = 1'b1;
    step(4);
    bus.cond = 4'h0;
    step(4);

    // Soft clear
    expect_at(1, "clr_all", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    clr = 1'b1;
    step(1);
    clr = 1'b0; bus.mode = 2'b00; bus.holdoff = 8'd3;
    step(2);

    // Toggle with holdoff=3: rises at spec edges 0,3,6 on ch0
    expect_at(2, "tog_pre",    4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(3, "tog_acc1",   4'hF, 4'h1, 4'h1, 4'h0, 16'h0001);
    expect_at(6, "tog_reject", 4'hF, 4'h1, 4'h0, 4'h1, 16'h0001);
    expect_at(9, "tog_acc2",   4'hF, 4'h0, 4'h1, 4'h1, 16'h0002);
    for (int k = 0; k < 8; k++) begin
      bus.cond = (k == 0 || k == 3 || k == 6) ? 4'b0001 : 4'b0000;
      step(1);
    end
    step(2);
    expect_at(1, "tog_clr", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);

    // Pulse, holdoff=4: single rise on ch1 -> 5 cycles high, busy 4
    bus.mode = 2'b10; bus.holdoff = 8'd4;
    expect_at(2, "pls_pre",   4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(3, "pls_start", 4'hF, 4'h2, 4'h2, 4'h0, 16'h0010);
    expect_at(6, "pls_busy",  4'hC, 4'h2, 4'h2, 4'h0, 16'h0000);
    expect_at(7, "pls_last",  4'hC, 4'h2, 4'h0, 4'h0, 16'h0000);
    expect_at(8, "pls_end",   4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
    bus.cond = 4'b0010;
    step(1);
    bus.cond = 4'b0000;
    step(9);

    // Pulse extended by a rise accepted on the would-be last cycle -> 10 high
    expect_at(3,  "ext_start",  4'h9, 4'h2, 4'h0, 4'h0, 16'h0020);
    expect_at(8,  "ext_reload", 4'hD, 4'h2, 4'h2, 4'h0, 16'h0030);
    expect_at(12, "ext_last",   4'hE, 4'h2, 4'h0, 4'h0, 16'h0030);
    expect_at(13, "ext_end",    4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
    bus.cond = 4'b0010;
    step(1);
    bus.cond = 4'b0000;
    step(4);
    bus.cond = 4'b0010;
    step(1);
    bus.cond = 4'b0000;
    step(12);

    // Follow: ch2 pattern 1,0,1 tracked with 2-edge latency
    bus.mode = 2'b01;
    expect_at(2, "fol_pre",  4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(3, "fol_1",    4'hD, 4'h4, 4'h4, 4'h0, 16'h0130);
    expect_at(4, "fol_0",    4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(5, "fol_1b",   4'hB, 4'h4, 4'h0, 4'h0, 16'h0130);
    expect_at(6, "fol_0b",   4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
    bus.cond = 4'b0100; step(1);
    bus.cond = 4'b0000; step(1);
    bus.cond = 4'b0100; step(1);
    bus.cond = 4'b0000; step(5);

    // Hold: raise ch2 in follow, then freeze and wiggle cond
    expect_at(3,  "hold_in",   4'hD, 4'h4, 4'h4, 4'h0, 16'h0230);
    expect_at(8,  "hold_mid",  4'h9, 4'h4, 4'h0, 4'h0, 16'h0230);
    expect_at(12, "hold_end",  4'hF, 4'h4, 4'h0, 4'h0, 16'h0230);
    bus.cond = 4'b0100;
    step(4);
    bus.mode = 2'b11;
    for (int k = 0; k < 5; k++) begin
      bus.cond = (k % 2 == 1) ? 4'b0100 : 4'b0000;
      step(1);
    end
    step(4);

    // Saturation: 20 spaced rises on ch3, holdoff=0, 4-bit counter
    bus.mode = 2'b00; bus.holdoff = 8'd0;
    expect_at(29, "sat_14",  4'h9, 4'h4, 4'h0, 4'h0, 16'hE230);
    expect_at(31, "sat_15",  4'h9, 4'hC, 4'h0, 4'h0, 16'hF230);
    expect_at(44, "sat_end", 4'hF, 4'h4, 4'h0, 4'h0, 16'hF230);
    for (int k = 0; k < 20; k++) begin
      bus.cond = 4'b1000; step(1);
      bus.cond = 4'b0000; step(1);
    end
    step(6);

    // Async reset asserted mid-pulse, then quiet release with cond=0
    bus.mode = 2'b10; bus.holdoff = 8'd8;
    expect_at(4, "pre_arst", 4'hF, 4'h1, 4'h1, 4'h0, 16'hF231);
    bus.cond = 4'b0001; step(1);
    bus.cond = 4'b0000; step(4);
    expect_at(0, "arst_now", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    reset = 1'b0;
    step(2);
    expect_at(2, "arst_rel2", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    expect_at(5, "arst_rel5", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    reset = 1'b1;
    step(8);

    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s never checked (due cyc %0d)", mon_e.name, mon_e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/photonic_rx_array.md
Name: photonic_rx_array

Overview:
Multi-channel, parametrised successor to the single-channel toggling receiver. Each channel synchronises an asynchronous condition input, detects its rising edge, and drives its switch-control output in one of four modes: toggle, follow, pulse or hold. Each channel has a programmable holdoff window, a sticky overrun flag and a saturating accepted-event counter. It sits between the condition sources and the photonic switch drivers, replacing per-channel receiver instances.

Parameters:
CHANNELS, 4, number of independent channels
SYNC_STAGES, 2, synchroniser depth on each cond bit (minimum 2)
HOLDOFF_W, 8, width of holdoff value and per-channel holdoff counter
COUNT_W, 8, width of each per-channel accepted-event counter

Ports:
clk  in  1  core clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately)
clr  in  1  synchronous, active-high soft clear; same effect as reset, applied at the clock edge
cond  in  CHANNELS  asynchronous per-channel condition inputs
mode  in  2  global mode: 00 toggle, 01 follow, 10 pulse, 11 hold
holdoff  in  HOLDOFF_W  holdoff length in cycles, sampled at each accepted edge
signal  out  CHANNELS  registered per-channel switch outputs
busy  out  CHANNELS  1 while the channel holdoff counter is nonzero
overrun  out  CHANNELS  sticky: a rise was rejected during holdoff
acc_count  out  CHANNELS*COUNT_W  per-channel accepted-event counts; channel i occupies bits [i*COUNT_W +: COUNT_W]

Behaviour:
- Reset or clr: signal=0, busy=0 (counter=0), overrun=0, acc_count=0. Synchroniser flops and the edge-detect delay flop are also set to 0. clr has priority over all other actions in its cycle.
- Per channel: cond passes through SYNC_STAGES flops to give cond_s. cond_d is cond_s delayed one cycle. rise = cond_s & ~cond_d.
- Latency: edge 0 is the edge that first samples cond=1. signal changes at edge SYNC_STAGES (edge 2 by default).
- Accept: rise=1 and counter==0 and mode!=hold. On accept:
  - counter is loaded with holdoff.
  - acc_count increments, saturating at all-ones.
  - The mode action below is applied.
- Reject: rise=1 and counter!=0 and mode is toggle or pulse. overrun is set. No other effect.
- Counter: decrements by 1 per cycle while nonzero, in all modes. An accept in the same cycle as the counter reaching 0 is allowed, because the accept condition is evaluated on the current counter value.
- After an accept at edge E, the next accept is possible at edge E+holdoff+1. holdoff=0 means back-to-back rises on consecutive cycles are never possible (rise needs cond_s low first), but there is no holdoff.
- Toggle mode (00): signal <= ~signal on accept.
- Pulse mode (10):
  - On accept, signal <= 1.
  - When not accepting and counter==0, signal <= 0.
  - signal is therefore high for exactly holdoff+1 cycles.
  - A rise accepted in the cycle where the pulse would end keeps signal=1 and reloads the counter.
- Follow mode (01): signal <= cond_s every cycle. Accepts still load the counter and count events. No reject or overrun in follow mode.
- Hold mode (11): signal frozen. Rises are neither accepted nor rejected. The counter keeps decrementing.
- Mode changes:
  - mode is sampled every cycle and is not registered.
  - Leaving pulse mode mid-pulse leaves signal at its current value.
  - Entering follow mode: signal equals cond_s from the next edge.
- Channels are fully independent. Simultaneous rises on several channels are each handled in the same cycle.
- Reset asserted mid-pulse or mid-holdoff clears everything immediately. On release, there is no spurious rise unless cond is high, in which case one rise occurs SYNC_STAGES edges after release.
- busy = (counter != 0), combinational from the register.

Test Plan:
- Reset values: hold reset=0 with cond=4'hF -> signal=0, busy=0, overrun=0, acc_count=0. Release with cond=4'hF, mode=00 -> each signal toggles to 1 exactly 2 edges after release, and acc_count=1 per channel.
- Toggle with holdoff: mode=00, holdoff=3, ch0 rises at edges 0, 3 and 6 -> signal[0] toggles at edges 2 and 8; the rise at edge 3 is rejected, overrun[0]=1, acc_count[0]=2. clr -> overrun[0]=0.
- Pulse: mode=10, holdoff=4, single rise on ch1 -> signal[1] high for exactly 5 cycles, busy[1] high for 4. A second rise is accepted on the cycle the pulse would end -> a single continuous 10-cycle high.
- Follow and hold: mode=01, drive ch2 with cond pattern 1,0,1 -> signal[2] tracks it with 2-cycle latency. Switch to mode=11 and toggle cond -> signal[2] frozen and acc_count[2] unchanged.
- Saturation and independence: COUNT_W=4, 20 spaced rises on ch3 with holdoff=0 -> acc_count[3]=15. Other channels stay unchanged.
- Async reset mid-operation: assert reset=0 between clock edges during a pulse -> all outputs 0 before the next clk edge. No output activity on release with cond=0.
